// File: rtl/mont_mult_seq_ctrl.sv
// Sequential Montgomery multiplier: drives a carry-save row array over all multiplier bits.
// Define MONT_MULT_SEQ_FINAL_REDUCE_EN to add the final reduction of the result into [0, M).

module mont_row_array #(
   parameter int                    DATA_WIDTH = 255,
   parameter logic [DATA_WIDTH-1:0] MODULUS    = 255'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001,
   parameter int                    ROW_NUM    = 17
) (
   input  logic [ROW_NUM-1:0]    i_x_temp,
   input  logic [DATA_WIDTH-1:0] i_y_temp,
   input  logic [DATA_WIDTH:0]   i_y_add_m,
   input  logic [DATA_WIDTH:0]   i_sum,
   input  logic [DATA_WIDTH:0]   i_carry,
   output logic [DATA_WIDTH:0]   o_sum,
   output logic [DATA_WIDTH:0]   o_carry
);

   // Each row holds S as (s >> 1) + c; s[0] is always 0 because q makes the row total even.
   always_comb begin : rows
      logic [DATA_WIDTH:0] w_a, w_b, w_add, w_s, w_c;
      logic                w_q;
      // NOTE: every variable gets a value before any conditional use, so no latch is inferred.
      w_a   = i_sum >> 1;
      w_b   = i_carry;
      w_add = '0;
      w_s   = '0;
      w_c   = '0;
      w_q   = 1'b0;
      for (int r = 0; r < ROW_NUM; r++) begin
         w_q = w_a[0] ^ w_b[0] ^ (i_x_temp[r] & i_y_temp[0]);
         case ({w_q, i_x_temp[r]})
            2'b00:   w_add = '0;
            2'b01:   w_add = {1'b0, i_y_temp};
            2'b10:   w_add = {1'b0, MODULUS};
            default: w_add = i_y_add_m;
         endcase
         w_s = w_a ^ w_b ^ w_add;
         w_c = (w_a & w_b) | (w_a & w_add) | (w_b & w_add);
         w_a = w_s >> 1;
         w_b = w_c;
      end
      o_sum   = w_s;
      o_carry = w_c;
   end

endmodule

module mont_mult_seq_ctrl #(
   parameter int                    DATA_WIDTH = 255,
   parameter logic [DATA_WIDTH-1:0] MODULUS    = 255'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001,
   parameter int                    ROW_NUM    = 17
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [DATA_WIDTH-1:0] x_i,
   input  logic [DATA_WIDTH-1:0] y_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH:0]   res_o,
   output logic                  busy_o
);

   localparam int                  ITER_NUM  = (DATA_WIDTH + ROW_NUM - 1) / ROW_NUM;
   localparam int                  X_W       = ITER_NUM * ROW_NUM;
   localparam int                  CNT_W     = $clog2(ITER_NUM + 1);
   localparam logic [CNT_W-1:0]    LAST_ITER = CNT_W'(ITER_NUM - 1);
   localparam logic [DATA_WIDTH:0] M_EXT     = {1'b0, MODULUS};

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_PRE    = 3'd1;
   localparam logic [2:0] S_ITER   = 3'd2;
   localparam logic [2:0] S_FINAL  = 3'd3;
`ifdef MONT_MULT_SEQ_FINAL_REDUCE_EN
   localparam logic [2:0] S_REDUCE = 3'd4;
`endif
   localparam logic [2:0] S_DONE   = 3'd5;

   logic [2:0]            r_state;
   logic [X_W-1:0]        r_x_sh;
   logic [DATA_WIDTH-1:0] r_y;
   logic [DATA_WIDTH:0]   r_ym;
   logic [DATA_WIDTH:0]   r_sum;
   logic [DATA_WIDTH:0]   r_carry;
   logic [CNT_W-1:0]      r_iter_cnt;
   logic [DATA_WIDTH:0]   r_res;
   logic [DATA_WIDTH:0]   w_sum;
   logic [DATA_WIDTH:0]   w_carry;

   mont_row_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .MODULUS    (MODULUS),
      .ROW_NUM    (ROW_NUM)
   ) u_rows (
      .i_x_temp  (r_x_sh[ROW_NUM-1:0]),
      .i_y_temp  (r_y),
      .i_y_add_m (r_ym),
      .i_sum     (r_sum),
      .i_carry   (r_carry),
      .o_sum     (w_sum),
      .o_carry   (w_carry)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: datapath registers are reset too, so an aborted operation leaves no residue on res_o.
         r_state    <= S_IDLE;
         r_x_sh     <= '0;
         r_y        <= '0;
         r_ym       <= '0;
         r_sum      <= '0;
         r_carry    <= '0;
         r_iter_cnt <= '0;
         r_res      <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         case (r_state)
            S_IDLE: begin
               if (in_valid_i) begin
                  r_x_sh     <= X_W'(x_i);
                  r_y        <= y_i;
                  r_sum      <= '0;
                  r_carry    <= '0;
                  r_iter_cnt <= '0;
                  r_state    <= S_PRE;
               end
            end
            S_PRE: begin
               r_ym    <= {1'b0, r_y} + M_EXT;
               r_state <= S_ITER;
            end
            S_ITER: begin
               r_sum      <= w_sum;
               r_carry    <= w_carry;
               r_x_sh     <= r_x_sh >> ROW_NUM;
               r_iter_cnt <= r_iter_cnt + 1'b1;
               if (r_iter_cnt == LAST_ITER) r_state <= S_FINAL;
            end
            S_FINAL: begin
               r_res <= (r_sum >> 1) + r_carry;
`ifdef MONT_MULT_SEQ_FINAL_REDUCE_EN
               r_state <= S_REDUCE;
`else
               r_state <= S_DONE;
`endif
            end
`ifdef MONT_MULT_SEQ_FINAL_REDUCE_EN
            S_REDUCE: begin
               if (r_res >= M_EXT) r_res <= r_res - M_EXT;
               r_state <= S_DONE;
            end
`endif
            S_DONE: begin
               if (out_ready_i) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready_o  = (r_state == S_IDLE);
   assign out_valid_o = (r_state == S_DONE);
   assign busy_o      = (r_state != S_IDLE);
   assign res_o       = r_res;

endmodule

// File: tb/tb_mont_mult_seq_ctrl.sv
// Bench for mont_mult_seq_ctrl: bit-serial Montgomery reference model, queue scoreboard, directed tests.
// Follows MONT_MULT_SEQ_FINAL_REDUCE_EN to select the reduced or redundant expectation.

module tb_mont_mult_seq_ctrl;

   localparam int DW   = 255;
   localparam int ROW  = 17;
   localparam int ITER = (DW + ROW - 1) / ROW;
   localparam int NB   = ITER * ROW;
   localparam logic [DW-1:0] MOD = 255'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001;
   localparam logic [DW:0]   M   = {1'b0, MOD};
`ifdef MONT_MULT_SEQ_FINAL_REDUCE_EN
   localparam bit REDUCE = 1'b1;
   localparam int LAT    = ITER + 4;
`else
   localparam bit REDUCE = 1'b0;
   localparam int LAT    = ITER + 3;
`endif

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] x_in;
   logic [DW-1:0] y_in;
   logic          out_valid;
   logic          out_ready;
   logic [DW:0]   res;
   logic          busy;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_done   = 0;
   logic [DW:0] exp_q[$];
   logic [DW:0] r_mod;

   mont_mult_seq_ctrl #(
      .DATA_WIDTH (DW),
      .MODULUS    (MOD),
      .ROW_NUM    (ROW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .x_i         (x_in),
      .y_i         (y_in),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .res_o       (res),
      .busy_o      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Textbook radix-2 Montgomery: S = (S + x_i*Y + q*M) / 2 for every multiplier bit.
   function automatic logic [DW:0] model(input logic [DW-1:0] x, input logic [DW-1:0] y);
      logic [NB-1:0] xp;
      logic [DW+2:0] s;
      xp = NB'(x);
      s  = '0;
      for (int i = 0; i < NB; i++) begin
         if (xp[i]) s = s + (DW+3)'(y);
         if (s[0])  s = s + (DW+3)'(M);
         s = s >> 1;
      end
      if (REDUCE && s >= (DW+3)'(M)) s = s - (DW+3)'(M);
      return s[DW:0];
   endfunction

   function automatic logic [DW:0] to_field(input logic [DW:0] v);
      return (v >= M) ? v - M : v;
   endfunction

   function automatic logic [DW-1:0] rnd();
      logic [255:0] r;
      r = {$urandom(), $urandom(), $urandom(), $urandom(),
           $urandom(), $urandom(), $urandom(), $urandom()};
      r = r % 256'(M);
      return r[DW-1:0];
   endfunction

   // Scoreboard: push the model result on accept, compare every cycle a result is shown.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL spurious result: got %0h, expected no pending operation", res);
            end else begin
               check("res vs model", res, exp_q[0]);
               check("in_ready in DONE", in_ready, 0);
               check("busy in DONE", busy, 1);
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  n_done++;
               end
            end
         end
         if (in_valid && in_ready) exp_q.push_back(model(x_in, y_in));
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the accept edge.
   task automatic send(input logic [DW-1:0] x, input logic [DW-1:0] y);
      int w;
      in_valid = 1'b1;
      x_in     = x;
      y_in     = y;
      w        = 0;
      do begin
         @(negedge clk);
         w++;
      end while (!in_ready && w < 200);
      check("accept", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int k);
      k = 0;
      while (!out_valid && k < 300) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("out_valid within bound", out_valid, 1);
   endtask

   task automatic drain();
      int w;
      w = 0;
      while ((exp_q.size() != 0 || out_valid) && w < 3000) begin
         @(posedge clk);
         #1;
         w++;
      end
      check("scoreboard drained", exp_q.size(), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int            k;
      int            acc;
      int            g;
      int            n0;
      logic          hs;
      logic [DW:0]   first;
      logic [DW:0]   red;
      logic [DW+2:0] wide;
      logic [511:0]  p;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      x_in      = '0;
      y_in      = '0;
      wide      = ((DW+3)'(1) << NB) % (DW+3)'(M);
      r_mod     = wide[DW:0];

      #12;
      check("reset in_ready", in_ready, 1);
      check("reset out_valid", out_valid, 0);
      check("reset busy", busy, 0);
      check("reset res", res, 0);
      check("model identity R*R^-1*5", model(r_mod[DW-1:0], 5), 5);
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      // x = 0: zero result and exact latency
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send('0, MOD - 1'b1);
      wait_valid(k);
      check("latency (cycles incl. accept)", k + 1, LAT);
      check("x=0 result", res, 0);
      drain();

      // x = R mod M, y = 5: Montgomery identity gives 5
      send(r_mod[DW-1:0], 5);
      wait_valid(k);
      check("x=R mod M, y=5", to_field(res), 5);
      drain();

      // (M-1)^2 = 1 mod M, so result * R must be 1 mod M
      send(MOD - 1'b1, MOD - 1'b1);
      wait_valid(k);
      check("(M-1)^2 range", REDUCE ? (res < M) : ({1'b0, res} < {M, 1'b0}), 1);
      red = to_field(res);
      p   = 512'(red) * 512'(r_mod);
      p   = p % 512'(M);
      check("(M-1)^2 * R mod M", p, 1);
      drain();

      // Backpressure: hold out_ready low 10 cycles in DONE
      out_ready = 1'b0;
      send(123456789, 987654321);
      wait_valid(k);
      first = res;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("hold out_valid", out_valid, 1);
         check("hold res stable", res, first);
         check("hold in_ready low", in_ready, 0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      x_in      = 2;
      y_in      = 9;
      @(negedge clk);
      check("no accept in DONE", in_ready, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("accept right after handshake", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      drain();

      // Reset pulse during the 7th ITER cycle
      send(MOD - 1'b1, 12345);
      repeat (7) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort in_ready", in_ready, 1);
      check("abort out_valid", out_valid, 0);
      check("abort busy", busy, 0);
      check("abort res", res, 0);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(3, 7);
      wait_valid(k);
      drain();

      // 100 back-to-back random ops with random backpressure
      n0        = n_done;
      acc       = 0;
      g         = 0;
      in_valid  = 1'b1;
      x_in      = rnd();
      y_in      = rnd();
      out_ready = 1'($urandom_range(0, 1));
      while (acc < 100 && g < 20000) begin
         @(negedge clk);
         hs = in_ready;
         @(posedge clk);
         #1;
         g++;
         if (hs) begin
            acc++;
            x_in = rnd();
            y_in = rnd();
         end
         out_ready = 1'($urandom_range(0, 1));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("random ops accepted", acc, 100);
      drain();
      check("random ops completed", n_done - n0, 100);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mont_mult_seq_ctrl.md
# mont_mult_seq_ctrl

Sequential controller that drives one carry-save Montgomery row array (ROW_NUM one-bit full-adder rows per cycle) through a full modular multiplication. It registers the operands, precomputes Y+M, iterates the row array over all multiplier bits, resolves the redundant sum/carry pair and reduces the result into [0, M). It is the field-multiplier unit used by the Poseidon round datapath, with a valid/ready handshake on both sides.

## Interface
- MODULUS, 255'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001: odd field modulus M, passed to the row array.
- DATA_WIDTH, 255: operand width.
- ROW_NUM, 17: multiplier bits consumed per iteration, equal to the row count of the array.
- ITER_NUM, localparam: ceil(DATA_WIDTH/ROW_NUM), 15 at defaults. R = 2^(ITER_NUM*ROW_NUM).

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid_i  in  1  operand pair valid.
- in_ready_o  out  1  controller accepts operands.
- x_i  in  DATA_WIDTH  multiplier; must be < M (not checked).
- y_i  in  DATA_WIDTH  multiplicand; must be < M (not checked).
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts result.
- res_o  out  DATA_WIDTH+1  x*y*R^-1 mod M; bit DATA_WIDTH is 0 when reduction is compiled in.
- busy_o  out  1  high in any state other than IDLE.

## Operation
- The block instantiates one row array with identical parameters. Registers: x_sh (ITER_NUM*ROW_NUM bits, zero-padded), y_r, ym_r (DATA_WIDTH+1), sum_r, carry_r (DATA_WIDTH+1), iter_cnt (ceil(log2(ITER_NUM+1)) bits), res_r.
- FSM states: IDLE, PRE, ITER, FINAL, REDUCE, DONE.
- IDLE: in_ready_o=1. On in_valid_i: x_sh<=x_i, y_r<=y_i, sum_r<=0, carry_r<=0, iter_cnt<=0, go to PRE.
- PRE: ym_r <= y_r + M, computed at full DATA_WIDTH+1 width with no truncation. Then go to ITER.
- ITER: array inputs are x_temp=x_sh[ROW_NUM-1:0], y_temp=y_r, y_add_m=ym_r, sum_r, carry_r. The array outputs load into sum_r/carry_r. x_sh shifts right by ROW_NUM and iter_cnt increments. After the ITER_NUM-th iteration, go to FINAL.
- FINAL: res_r <= (sum_r >> 1) + carry_r, using DATA_WIDTH+1 bits. The value is < 2M. Go to REDUCE, or to DONE when reduction is compiled out.
- REDUCE: if res_r >= M, res_r <= res_r - M. Go to DONE.
- DONE: out_valid_o=1 and res_o=res_r held stable. On out_ready_i, go to IDLE.
- in_ready_o is combinationally equal to (state==IDLE). A new operand pair is never accepted in DONE, even when out_ready_i is high in the same cycle.
- The array's combinational path must close in one cycle. No multicycle constraint.

## Timing
- Reset (async assert, sync release): state=IDLE, in_ready_o=1, out_valid_o=0, busy_o=0, res_o=0, all datapath registers 0.
- Latency from the accept edge to the first cycle with out_valid_o high:
  - ITER_NUM+4 cycles (19 at defaults) with reduction compiled in.
  - ITER_NUM+3 cycles (18) without it.
- Throughput: one result per latency+1 cycles when out_ready_i is held high.
- Backpressure: out_valid_o, res_o and busy_o stay stable until the handshake. in_valid_i is ignored outside IDLE, and x_i/y_i are not sampled outside IDLE.
- Reset asserted mid-operation (any state): the operation is aborted immediately, with no result and no residue. The first operation after reset is bit-exact.
- iter_cnt never wraps. It is cleared on accept and compared against ITER_NUM-1.

## Configuration
- MONT_MULT_SEQ_FINAL_REDUCE_EN defined: the REDUCE state exists and res_o < M, with bit DATA_WIDTH = 0.
- Macro not defined: the REDUCE state and its comparator/subtractor are removed, FINAL goes directly to DONE, and res_o is the redundant value in [0, 2M) (congruent result, DATA_WIDTH+1 bits).

## Test plan
- x=0, y=M-1 -> res_o=0, with out_valid_o rising exactly 19 cycles after accept (18 without the macro).
- x=R mod M (model constant), y=5 -> res_o=5. Checks the Montgomery identity x*y*R^-1.
- x=M-1, y=M-1 -> res_o equals the model value of (M-1)^2*R^-1 mod M. With the macro it is < M; without it, it is congruent and < 2M.
- out_ready_i held low for 10 cycles in DONE -> out_valid_o=1, res_o constant and in_ready_o=0 throughout; the result is accepted on the cycle out_ready_i rises.
- rst_n pulsed low at the 7th ITER cycle -> all outputs return to reset values asynchronously. The next op (x=3, y=7) matches the model.
- 100 random back-to-back ops with in_valid_i always high and random out_ready_i -> every result matches the model, with no dropped or duplicated transactions.
